// File: rtl/initial_shift_controller.sv
// Sequences one wrap-around step: fetch normal words 0/551/552 and the target accumulator
// word, run one processor start/done handshake, then write the result back to the accumulator.
module initial_shift_controller #(
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_BITS   = 17669,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [15:0]           shift,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  norm_rd_en,
    output logic [ADDR_WIDTH-1:0] norm_rd_addr,
    input  logic [WORD_WIDTH-1:0] norm_rd_data,
    output logic                  acc_rd_en,
    output logic [ADDR_WIDTH-1:0] acc_rd_addr,
    input  logic [WORD_WIDTH-1:0] acc_rd_data,
    output logic                  acc_wr_en,
    output logic [ADDR_WIDTH-1:0] acc_wr_addr,
    output logic [WORD_WIDTH-1:0] acc_wr_data,
    output logic                  proc_start,
    output logic [WORD_WIDTH-1:0] proc_word_zero,
    output logic [WORD_WIDTH-1:0] proc_word_551,
    output logic [WORD_WIDTH-1:0] proc_word_552,
    output logic [WORD_WIDTH-1:0] proc_acc_word,
    output logic [15:0]           proc_shift,
    output logic [4:0]            proc_acc_shift_idx,
    input  logic [WORD_WIDTH-1:0] proc_result,
    input  logic                  proc_done
);
    localparam int LAST_WORD = (NUM_BITS - 1) / WORD_WIDTH;
    localparam int CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(LAST_WORD);
    localparam logic [ADDR_WIDTH-1:0] ADDR_PEN  = ADDR_WIDTH'(LAST_WORD - 1);
    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_RD0, S_RD1, S_RD2, S_CAP, S_KICK, S_WAIT, S_WB, S_DONE
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      wait_cnt;
    logic                  shift_bad;
    logic [ADDR_WIDTH-1:0] new_tgt;
    logic [ADDR_WIDTH-1:0] tgt;

    assign shift_bad = ({16'd0, shift} >= 32'(NUM_BITS));
    assign new_tgt   = ADDR_WIDTH'(shift[15:5]);
    assign tgt       = ADDR_WIDTH'(proc_shift[15:5]);

    // Outputs are registered on entry to the state that owns them, so each strobe
    // is high for exactly the cycles its state occupies.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= S_IDLE;
            wait_cnt           <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            err                <= 1'b0;
            norm_rd_en         <= 1'b0;
            norm_rd_addr       <= '0;
            acc_rd_en          <= 1'b0;
            acc_rd_addr        <= '0;
            acc_wr_en          <= 1'b0;
            acc_wr_addr        <= '0;
            acc_wr_data        <= '0;
            proc_start         <= 1'b0;
            proc_word_zero     <= '0;
            proc_word_551      <= '0;
            proc_word_552      <= '0;
            proc_acc_word      <= '0;
            proc_shift         <= '0;
            proc_acc_shift_idx <= '0;
        end else begin
            norm_rd_en <= 1'b0;
            acc_rd_en  <= 1'b0;
            acc_wr_en  <= 1'b0;
            proc_start <= 1'b0;
            done       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy               <= 1'b1;
                        proc_shift         <= shift;
                        proc_acc_shift_idx <= shift[4:0];
                        if (shift_bad) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            err          <= 1'b0;
                            norm_rd_en   <= 1'b1;
                            norm_rd_addr <= '0;
                            acc_rd_en    <= 1'b1;
                            acc_rd_addr  <= new_tgt;
                            state        <= S_RD0;
                        end
                    end
                end
                S_RD0: begin
                    norm_rd_en   <= 1'b1;
                    norm_rd_addr <= ADDR_PEN;
                    state        <= S_RD1;
                end
                S_RD1: begin
                    proc_word_zero <= norm_rd_data;
                    proc_acc_word  <= acc_rd_data;
                    norm_rd_en     <= 1'b1;
                    norm_rd_addr   <= ADDR_LAST;
                    state          <= S_RD2;
                end
                S_RD2: begin
                    proc_word_551 <= norm_rd_data;
                    state         <= S_CAP;
                end
                S_CAP: begin
                    proc_word_552 <= norm_rd_data;
                    proc_start    <= 1'b1;
                    state         <= S_KICK;
                end
                S_KICK: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (proc_done) begin
                        acc_wr_en   <= 1'b1;
                        acc_wr_addr <= tgt;
                        acc_wr_data <= proc_result;
                        state       <= S_WB;
                    end else if (wait_cnt == CNT_LAST) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_WB: begin
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_initial_shift_controller.sv
// Bench for initial_shift_controller: behavioural RAMs, a fixed-latency processor stub and an
// event log compared against schedules derived from the block's timing rules.
module tb_initial_shift_controller;
    localparam int WW = 32;
    localparam int AW = 10;
    localparam int NB = 17669;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [15:0]   shift = '0;
    logic          busy, done, err;
    logic          norm_rd_en, acc_rd_en, acc_wr_en, proc_start, proc_done;
    logic [AW-1:0] norm_rd_addr, acc_rd_addr, acc_wr_addr;
    logic [WW-1:0] norm_rd_data, acc_rd_data, acc_wr_data, proc_result;
    logic [WW-1:0] proc_word_zero, proc_word_551, proc_word_552, proc_acc_word;
    logic [15:0]   proc_shift;
    logic [4:0]    proc_acc_shift_idx;

    initial_shift_controller #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .NUM_BITS(NB), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .shift(shift), .busy(busy), .done(done), .err(err),
        .norm_rd_en(norm_rd_en), .norm_rd_addr(norm_rd_addr), .norm_rd_data(norm_rd_data),
        .acc_rd_en(acc_rd_en), .acc_rd_addr(acc_rd_addr), .acc_rd_data(acc_rd_data),
        .acc_wr_en(acc_wr_en), .acc_wr_addr(acc_wr_addr), .acc_wr_data(acc_wr_data),
        .proc_start(proc_start), .proc_word_zero(proc_word_zero), .proc_word_551(proc_word_551),
        .proc_word_552(proc_word_552), .proc_acc_word(proc_acc_word), .proc_shift(proc_shift),
        .proc_acc_shift_idx(proc_acc_shift_idx), .proc_result(proc_result), .proc_done(proc_done)
    );

    always #5 clk = ~clk;

    // Memories with a bench-side load port; the only writers live in this one process.
    logic [WW-1:0] norm_mem [1024];
    logic [WW-1:0] acc_mem  [1024];
    logic          tb_we = 1'b0, tb_sel = 1'b0;
    logic [AW-1:0] tb_addr = '0;
    logic [WW-1:0] tb_dat = '0;
    always @(posedge clk) begin
        if (norm_rd_en) norm_rd_data <= norm_mem[norm_rd_addr];
        if (acc_rd_en)  acc_rd_data  <= acc_mem[acc_rd_addr];
        if (acc_wr_en)  acc_mem[acc_wr_addr] <= acc_wr_data;
        if (tb_we) begin
            if (tb_sel) acc_mem[tb_addr] <= tb_dat;
            else        norm_mem[tb_addr] <= tb_dat;
        end
    end

    // Processor stub: done three cycles after start, result mixes every operand.
    logic [2:0] pipe = '0;
    bit         proc_en = 1'b1;
    always @(posedge clk) pipe <= {pipe[1:0], proc_start};
    assign proc_done   = pipe[2] & proc_en;
    assign proc_result = proc_word_zero ^ proc_word_551 ^ proc_word_552 ^ proc_acc_word ^ {16'h0, proc_shift};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit          rec = 1'b0;
    int          t0, busy_n;
    int          n_cyc[$], n_addr[$], a_cyc[$], a_addr[$], w_cyc[$], w_addr[$], ps_cyc[$], d_cyc[$];
    logic        d_err[$];
    logic [31:0] w_dat[$];
    always @(negedge clk) begin
        if (rec) begin
            if (norm_rd_en) begin n_cyc.push_back(cyc); n_addr.push_back(int'(norm_rd_addr)); end
            if (acc_rd_en)  begin a_cyc.push_back(cyc); a_addr.push_back(int'(acc_rd_addr)); end
            if (acc_wr_en)  begin w_cyc.push_back(cyc); w_addr.push_back(int'(acc_wr_addr)); w_dat.push_back(acc_wr_data); end
            if (proc_start) ps_cyc.push_back(cyc);
            if (done)       begin d_cyc.push_back(cyc); d_err.push_back(err); end
            if (busy)       busy_n++;
        end
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        n_cyc.delete(); n_addr.delete(); a_cyc.delete(); a_addr.delete();
        w_cyc.delete(); w_addr.delete(); w_dat.delete(); ps_cyc.delete();
        d_cyc.delete(); d_err.delete(); busy_n = 0;
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_ctl"}, {busy, done, err, norm_rd_en, acc_rd_en, acc_wr_en, proc_start}, 0);
        chk({pfx, "_addr"}, {norm_rd_addr, acc_rd_addr, acc_wr_addr}, 0);
        chk({pfx, "_data"}, 64'(|{acc_wr_data, proc_word_zero, proc_word_551, proc_word_552, proc_acc_word}), 0);
        chk({pfx, "_shift"}, {proc_shift, proc_acc_shift_idx}, 0);
    endtask

    // One operation; the expected schedule comes from the documented cycle plan.
    task automatic do_op(input logic [15:0] sh, input bit pen, input bit pulse);
        bit          valid, got;
        int          tgt, exp_done;
        int          exp_na[3];
        logic [31:0] k, a_old;
        exp_na   = '{0, 551, 552};
        valid    = (int'(sh) < NB);
        tgt      = int'(sh) >> 5;
        k        = norm_mem[0] ^ norm_mem[551] ^ norm_mem[552] ^ {16'h0, sh};
        a_old    = '0;
        if (valid) a_old = acc_mem[tgt];
        exp_done = !valid ? 1 : (pen ? 10 : 5 + TO + 1);
        clear_logs();
        proc_en = pen;
        @(negedge clk); shift = sh; start = 1'b1; rec = 1'b1;
        @(negedge clk); t0 = cyc; start = 1'b0; got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            if (done) got = 1'b1;
            else begin
                start = pulse && ((cyc - t0 + 1) == 6);
                if (start) shift = 16'd3;
                @(negedge clk);
            end
        end
        start = 1'b0;
        @(negedge clk); rec = 1'b0;
        chk("done_seen", 64'(got), 1);
        chk("done_cnt", d_cyc.size(), 1);
        if (d_cyc.size() == 1) begin
            chk("done_cycle", d_cyc[0] - t0 + 1, exp_done);
            chk("err", 64'(d_err[0]), 64'(!(valid && pen)));
        end
        chk("busy_cycles", busy_n, exp_done);
        chk("busy_idle", 64'(busy), 0);
        chk("norm_rd_cnt", n_cyc.size(), valid ? 3 : 0);
        if (valid && n_cyc.size() == 3)
            for (int j = 0; j < 3; j++) begin
                chk($sformatf("norm_rd_cyc%0d", j), n_cyc[j] - t0 + 1, j + 1);
                chk($sformatf("norm_rd_addr%0d", j), n_addr[j], exp_na[j]);
            end
        chk("acc_rd_cnt", a_cyc.size(), valid ? 1 : 0);
        if (valid && a_cyc.size() == 1) begin
            chk("acc_rd_cyc", a_cyc[0] - t0 + 1, 1);
            chk("acc_rd_addr", a_addr[0], tgt);
        end
        chk("proc_start_cnt", ps_cyc.size(), valid ? 1 : 0);
        if (valid && ps_cyc.size() == 1) chk("proc_start_cyc", ps_cyc[0] - t0 + 1, 5);
        chk("wr_cnt", w_cyc.size(), (valid && pen) ? 1 : 0);
        if (valid && pen && w_cyc.size() == 1) begin
            chk("wr_cyc", w_cyc[0] - t0 + 1, 9);
            chk("wr_addr", w_addr[0], tgt);
            chk("wr_data", w_dat[0], k ^ a_old);
            chk("acc_after", acc_mem[tgt], k ^ a_old);
        end
        if (valid) begin
            chk("op_zero", proc_word_zero, norm_mem[0]);
            chk("op_551", proc_word_551, norm_mem[551]);
            chk("op_552", proc_word_552, norm_mem[552]);
            chk("op_acc", proc_acc_word, a_old);
            chk("op_shift", proc_shift, sh);
            chk("op_idx", proc_acc_shift_idx, sh % 32);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] k, a;
        #1;
        chk_zero("reset");
        for (int i = 0; i < 553; i++) begin
            @(negedge clk); tb_we = 1'b1; tb_sel = 1'b1; tb_addr = AW'(i); tb_dat = $urandom;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); tb_sel = 1'b0; tb_addr = (i == 0) ? AW'(0) : AW'(550 + i); tb_dat = $urandom;
        end
        @(negedge clk); tb_we = 1'b0;
        chk_zero("reset_hold");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_op(16'd71, 1'b1, 1'b0);
        do_op(16'd3, 1'b1, 1'b0);
        do_op(16'd17668, 1'b1, 1'b0);
        do_op(16'd17669, 1'b1, 1'b0);
        do_op(16'd71, 1'b1, 1'b1);

        // start held high: two back-to-back operations on the same word
        k = norm_mem[0] ^ norm_mem[551] ^ norm_mem[552] ^ 32'd71;
        a = acc_mem[2];
        clear_logs();
        proc_en = 1'b1;
        @(negedge clk); shift = 16'd71; start = 1'b1; rec = 1'b1;
        @(negedge clk); t0 = cyc;
        for (int i = 0; i < 26; i++) begin
            if ((cyc - t0 + 1) == 12) start = 1'b0;
            @(negedge clk);
        end
        start = 1'b0; rec = 1'b0;
        chk("held_done_cnt", d_cyc.size(), 2);
        if (d_cyc.size() == 2) chk("held_done_cyc", {32'(d_cyc[0] - t0 + 1), 32'(d_cyc[1] - t0 + 1)}, {32'd10, 32'd21});
        chk("held_wr_cnt", w_cyc.size(), 2);
        if (w_cyc.size() == 2) begin
            chk("held_wr_cyc", {32'(w_cyc[0] - t0 + 1), 32'(w_cyc[1] - t0 + 1)}, {32'd9, 32'd20});
            chk("held_wr_dat", {w_dat[0], w_dat[1]}, {k ^ a, a});
        end
        chk("held_ps_cnt", ps_cyc.size(), 2);

        do_op(16'd71, 1'b0, 1'b0);
        do_op(16'd200, 1'b1, 1'b0);
        for (int r = 0; r < 4; r++) do_op(16'($urandom_range(0, NB - 1)), 1'b1, 1'b0);
        do_op(16'($urandom_range(NB, 65535)), 1'b1, 1'b0);

        // reset asserted while waiting on the processor
        a = acc_mem[2];
        clear_logs();
        proc_en = 1'b1;
        @(negedge clk); shift = 16'd71; start = 1'b1; rec = 1'b1;
        @(negedge clk); t0 = cyc; start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        repeat (3) @(negedge clk);
        rec = 1'b0;
        chk("midrst_no_wr", w_cyc.size(), 0);
        chk("midrst_acc", acc_mem[2], a);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(16'd71, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
